// File: rtl/adder_tb_pkg.sv
// Shared definitions for the adder test environment: LFSR polynomial,
// generator FSM encoding, corner-vector count and operand word sizing.
package adder_tb_pkg;

  localparam logic [31:0] lfsr_poly = 32'h80200003;
  localparam int          ncorner   = 4;

  typedef enum logic [2:0] {
    st_idle,
    st_corner,
    st_fill,
    st_hold,
    st_done
  } state_t;

  // Number of 32-bit LFSR words needed to cover one operand.
  function automatic int words(input int width);
    return (width + 31) / 32;
  endfunction

  // One right-shift Galois step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? lfsr_poly : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shift Galois LFSR with load and step enables.
module lfsr32_galois
  import adder_tb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  // Reset and load both restart the sequence from the seed.
  always_ff @(posedge clk) begin
    if (rst || load) state <= seed;
    else if (step)   state <= lfsr_next(state);
  end

endmodule

// File: rtl/adder_vector_gen.sv
// Operand source for the adder test environment: a fixed set of carry-chain
// corner vectors followed by LFSR-filled random vectors, valid/ready delivery.
module adder_vector_gen
  import adder_tb_pkg::*;
#(
  parameter int          n         = 256,
  parameter int          file_size = 30000,
  parameter logic [31:0] SEED      = 32'h00000001
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ready,
  output logic          valid,
  output logic [n-1:0]  a,
  output logic [n-1:0]  b,
  output logic          cin,
  output logic [31:0]   idx,
  output logic          busy,
  output logic          done
);

  localparam int          w         = words(n);
  localparam logic [31:0] fs        = 32'(file_size);
  localparam logic [15:0] fill_last = 16'(2 * w);

  state_t      state, nstate;
  logic [15:0] cnt;
  logic [31:0] lfsr_s, s_next, idx_inc;
  logic        xfer, lfsr_load, lfsr_step;

  assign xfer      = valid && ready;
  assign idx_inc   = idx + 32'd1;
  assign s_next    = lfsr_next(lfsr_s);
  assign lfsr_load = start && (state == st_idle);
  assign lfsr_step = (state == st_fill);

  // Corner vector k packed as {cin, a, b}.
  function automatic logic [2*n:0] corner_vec(input logic [1:0] k);
    logic [n-1:0] ca, cb;
    logic         cc;
    ca = '0;
    cb = '0;
    cc = 1'b0;
    case (k)
      2'd1: begin ca = '1; cc = 1'b1; end
      2'd2: begin ca = '1; cb = '1; cc = 1'b1; end
      2'd3: begin
        for (int i = 0; i < n; i++) begin
          ca[i] = ~i[0];
          cb[i] = i[0];
        end
        cc = 1'b1;
      end
      default: ;
    endcase
    return {cc, ca, cb};
  endfunction

  lfsr32_galois u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (SEED),
    .step  (lfsr_step),
    .state (lfsr_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= st_idle;
    else     state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      st_idle, st_done: begin
        if (start) nstate = (file_size == 0) ? st_done : st_corner;
      end
      st_corner: begin
        if (xfer) begin
          if (idx_inc == fs)                   nstate = st_done;
          else if (idx_inc == 32'(ncorner))    nstate = st_fill;
        end
      end
      st_fill: begin
        if (cnt == fill_last) nstate = st_hold;
      end
      st_hold: begin
        if (xfer) nstate = (idx_inc == fs) ? st_done : st_fill;
      end
      default: nstate = st_idle;
    endcase
  end

  // Vector registers, index, fill counter and run status.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      cin   <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        st_idle, st_done: begin
          if (start) begin
            idx <= '0;
            if (file_size == 0) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              done           <= 1'b0;
              busy           <= 1'b1;
              valid          <= 1'b1;
              {cin, a, b}    <= corner_vec(2'd0);
            end
          end
        end
        st_corner: begin
          if (xfer) begin
            idx <= idx_inc;
            if (nstate == st_done) begin
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (nstate == st_fill) begin
              valid <= 1'b0;
              cnt   <= '0;
            end else begin
              {cin, a, b} <= corner_vec(idx_inc[1:0]);
            end
          end
        end
        st_fill: begin
          cnt <= cnt + 16'd1;
          if (cnt < 16'(w)) begin
            for (int i = 0; i < n; i++)
              if (i / 32 == int'(cnt)) a[i] <= s_next[i[4:0]];
          end else if (cnt < fill_last) begin
            for (int i = 0; i < n; i++)
              if (i / 32 == int'(cnt) - w) b[i] <= s_next[i[4:0]];
          end else begin
            cin   <= s_next[0];
            valid <= 1'b1;
          end
        end
        st_hold: begin
          if (xfer) begin
            idx   <= idx_inc;
            valid <= 1'b0;
            cnt   <= '0;
            if (nstate == st_done) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_vector_gen.sv
// Bench for adder_vector_gen: several parameterisations driven with
// directed and random-ready stimulus against a behavioural vector model.
module tb_adder_vector_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, readyx;

  // n=8, file_size=6
  logic start8, ready8, valid8, cin8, busy8, done8;
  logic [7:0] a8, b8;
  logic [31:0] idx8;
  // n=8, file_size=2
  logic start2, valid2, cin2, busy2, done2;
  logic [7:0] a2, b2;
  logic [31:0] idx2;
  // n=8, file_size=0
  logic startz, validz, cinz, busyz, donez;
  logic [7:0] az, bz;
  logic [31:0] idxz;
  // n=256, file_size=5
  logic startw, validw, cinw, busyw, donew;
  logic [255:0] aw, bw;
  logic [31:0] idxw;

  adder_vector_gen #(.n(8), .file_size(6), .SEED(32'h1)) d8 (
    .clk(clk), .rst(rst), .start(start8), .ready(ready8), .valid(valid8),
    .a(a8), .b(b8), .cin(cin8), .idx(idx8), .busy(busy8), .done(done8));
  adder_vector_gen #(.n(8), .file_size(2), .SEED(32'h1)) d2 (
    .clk(clk), .rst(rst), .start(start2), .ready(readyx), .valid(valid2),
    .a(a2), .b(b2), .cin(cin2), .idx(idx2), .busy(busy2), .done(done2));
  adder_vector_gen #(.n(8), .file_size(0), .SEED(32'h1)) dz (
    .clk(clk), .rst(rst), .start(startz), .ready(readyx), .valid(validz),
    .a(az), .b(bz), .cin(cinz), .idx(idxz), .busy(busyz), .done(donez));
  adder_vector_gen #(.n(256), .file_size(5), .SEED(32'h1)) dw (
    .clk(clk), .rst(rst), .start(startw), .ready(readyx), .valid(validw),
    .a(aw), .b(bw), .cin(cinw), .idx(idxw), .busy(busyw), .done(donew));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural model of the vector stream.
  logic [31:0] ms8, msw;

  function automatic logic [31:0] mstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [255:0] mmask(input int nb);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < nb; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic mcorner(input int k, input int nb, output logic [255:0] ea,
                         output logic [255:0] eb, output logic ec);
    ea = '0; eb = '0; ec = (k != 0);
    if (k == 1) ea = mmask(nb);
    if (k == 2) begin ea = mmask(nb); eb = mmask(nb); end
    if (k == 3)
      for (int i = 0; i < nb; i++) begin
        ea[i] = (i % 2 == 0);
        eb[i] = (i % 2 == 1);
      end
  endtask

  task automatic mrand(input int nb, inout logic [31:0] s, output logic [255:0] ea,
                       output logic [255:0] eb, output logic ec);
    int wn;
    wn = (nb + 31) / 32;
    ea = '0; eb = '0;
    for (int j = 0; j < wn; j++) begin s = mstep(s); ea[32*j +: 32] = s; end
    for (int j = 0; j < wn; j++) begin s = mstep(s); eb[32*j +: 32] = s; end
    s  = mstep(s);
    ec = s[0];
    ea = ea & mmask(nb);
    eb = eb & mmask(nb);
  endtask

  logic [255:0] ea [8];
  logic [255:0] eb [8];
  logic         ec [8];
  logic [7:0]   oa [8];
  logic [7:0]   ob [8];
  logic         oc [8];

  // One full n=8 run. mode 0: ready=1; mode 1: 5-cycle stall on idx 4;
  // mode 2: random ready every cycle.
  task automatic run8(input int mode, input bit lit);
    int nx, cyc, stall;
    bit r;
    for (int k = 0; k < 6; k++)
      if (k < 4) mcorner(k, 8, ea[k], eb[k], ec[k]);
      else       mrand(8, ms8, ea[k], eb[k], ec[k]);
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    nx = 0; cyc = 0; stall = 0;
    while (nx < 6 && cyc < 300) begin
      r = 1'($urandom_range(0, 1));
      if (valid8) begin
        check("vec_a",   {248'b0, a8},   ea[nx]);
        check("vec_b",   {248'b0, b8},   eb[nx]);
        check("vec_cin", {255'b0, cin8}, {255'b0, ec[nx]});
        check("vec_idx", {224'b0, idx8}, 256'(nx));
        check("busy",    {255'b0, busy8}, 256'd1);
        if (mode == 0) r = 1'b1;
        if (mode == 1) begin
          if (nx == 4 && stall < 5) begin r = 1'b0; stall++; end
          else r = 1'b1;
        end
      end
      ready8 = r;
      if (valid8 && r) begin
        oa[nx] = a8; ob[nx] = b8; oc[nx] = cin8;
        nx++;
      end
      @(negedge clk);
      cyc++;
    end
    ready8 = 1'b0;
    check("xfer_count", 256'(nx), 256'd6);
    check("done_at_end",  {255'b0, done8},  256'd1);
    check("busy_at_end",  {255'b0, busy8},  256'd0);
    check("valid_at_end", {255'b0, valid8}, 256'd0);
    if (lit) begin
      check("s1_a0", {248'b0, oa[0]}, 256'h00);
      check("s1_a1", {248'b0, oa[1]}, 256'hFF);
      check("s1_c1", {255'b0, oc[1]}, 256'h1);
      check("s1_b2", {248'b0, ob[2]}, 256'hFF);
      check("s1_a3", {248'b0, oa[3]}, 256'h55);
      check("s1_b3", {248'b0, ob[3]}, 256'hAA);
      check("s1_a4", {248'b0, oa[4]}, 256'h03);
      check("s1_b4", {248'b0, ob[4]}, 256'h02);
      check("s1_c4", {255'b0, oc[4]}, 256'h1);
    end
  endtask

  initial begin
    int nx, cyc, gap;
    int tx [5];
    logic [31:0] wa;
    bit sawv;
    rst = 1'b1; readyx = 1'b1; ready8 = 1'b0;
    start8 = 0; start2 = 0; startz = 0; startw = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_valid", {255'b0, valid8}, 256'd0);
    check("rst_a",     {248'b0, a8},     256'd0);
    check("rst_idx",   {224'b0, idx8},   256'd0);
    check("rst_busy",  {255'b0, busy8},  256'd0);
    check("rst_done",  {255'b0, done8},  256'd0);

    // file_size=2: only two corners, LFSR untouched
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    nx = 0; cyc = 0; wa = '0;
    while (!done2 && cyc < 50) begin
      if (valid2) begin
        if (nx == 1) wa = {24'b0, a2};
        nx++;
      end
      @(negedge clk); cyc++;
    end
    check("fs2_xfers", 256'(nx), 256'd2);
    check("fs2_a1",    {224'b0, wa}, 256'hFF);
    check("fs2_done",  {255'b0, done2}, 256'd1);
    check("fs2_lfsr",  {224'b0, d2.u_lfsr.state}, 256'h1);

    // file_size=0: straight to DONE
    @(negedge clk); startz = 1'b1;
    sawv = validz;
    @(negedge clk); startz = 1'b0;
    check("fs0_done",  {255'b0, donez},  256'd1);
    check("fs0_busy",  {255'b0, busyz},  256'd0);
    repeat (5) begin sawv = sawv | validz; @(negedge clk); end
    check("fs0_valid", {255'b0, sawv}, 256'd0);

    // n=256 throughput and word order
    msw = 32'h1;
    for (int k = 0; k < 5; k++)
      if (k < 4) mcorner(k, 256, ea[k], eb[k], ec[k]);
      else       mrand(256, msw, ea[k], eb[k], ec[k]);
    @(negedge clk); startw = 1'b1;
    @(negedge clk); startw = 1'b0;
    nx = 0; cyc = 0; wa = '0;
    while (nx < 5 && cyc < 200) begin
      if (validw) begin
        check("w_a",   aw, ea[nx]);
        check("w_b",   bw, eb[nx]);
        check("w_cin", {255'b0, cinw}, {255'b0, ec[nx]});
        tx[nx] = cyc;
        if (nx == 4) wa = aw[31:0];
        nx++;
      end
      @(negedge clk); cyc++;
    end
    check("w_xfers", 256'(nx), 256'd5);
    gap = (nx == 5) ? tx[4] - tx[3] : -1;
    check("w_gap",   256'(gap), 256'd18);
    check("w_a_lo",  {224'b0, wa}, 256'h80200003);
    check("w_done",  {255'b0, donew}, 256'd1);

    // n=8 directed runs, then random ready
    ms8 = 32'h1;
    run8(0, 1'b1);
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    ms8 = 32'h1;
    run8(1, 1'b1);
    repeat (4) run8(2, 1'b0);

    // reset during FILL, then rerun from SEED
    @(negedge clk); start8 = 1'b1; ready8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    nx = 0; cyc = 0;
    while (nx < 4 && cyc < 50) begin
      if (valid8) nx++;
      @(negedge clk); cyc++;
    end
    check("s5_reach_fill", 256'(nx), 256'd4);
    rst = 1'b1; ready8 = 1'b0;
    @(negedge clk); rst = 1'b0;
    check("s5_valid", {255'b0, valid8}, 256'd0);
    check("s5_a",     {248'b0, a8},     256'd0);
    check("s5_b",     {248'b0, b8},     256'd0);
    check("s5_cin",   {255'b0, cin8},   256'd0);
    check("s5_idx",   {224'b0, idx8},   256'd0);
    check("s5_busy",  {255'b0, busy8},  256'd0);
    check("s5_done",  {255'b0, done8},  256'd0);
    ms8 = 32'h1;
    run8(0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
